// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, enable levels, FSM encoding
// and the request timeout test.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int TMO_W       = 8;

    localparam logic [INST_W-1:0] ZERO_WORD   = '0;
    localparam logic              CHIP_ENABLE = 1'b1;
    localparam logic              RST_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_e;

    // True when the current unacknowledged cycle is the last one allowed.
    function automatic logic tmo_expired(input logic [TMO_W-1:0] cnt,
                                         input logic [TMO_W-1:0] limit);
        return ({1'b0, cnt} + {{TMO_W{1'b0}}, 1'b1}) >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding ROM request, a single-entry
// instruction buffer and a stall request towards the pipeline controller.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 8'd255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   ce_i,
    input  logic                   flush,
    input  logic                   rom_ack_i,
    input  logic [INST_W-1:0]      rom_data_i,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   stallreq_o,
    output logic                   fetch_err_o
);

    fetch_state_e           state_reg;
    logic                   rom_ce_reg;
    logic [INST_ADDR_W-1:0] rom_addr_reg;
    logic [INST_W-1:0]      inst_buf_reg;
    logic [INST_ADDR_W-1:0] buf_pc_reg;
    logic [TMO_W-1:0]       tmo_cnt_reg;
    logic                   fetch_err_reg;

    logic fetch_en;
    logic fetch_valid;
    logic tmo_hit;

    assign fetch_en = (ce_i == CHIP_ENABLE);
    assign tmo_hit  = tmo_expired(tmo_cnt_reg, TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg     <= FETCH_IDLE;
            rom_ce_reg    <= 1'b0;
            rom_addr_reg  <= ZERO_WORD;
            inst_buf_reg  <= ZERO_WORD;
            buf_pc_reg    <= ZERO_WORD;
            tmo_cnt_reg   <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            fetch_err_reg <= 1'b0;
            case (state_reg)
                FETCH_IDLE: begin
                    // Acks arriving here belong to an abandoned request.
                    if (fetch_en && !flush) begin
                        rom_addr_reg <= pc_i;
                        rom_ce_reg   <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (rom_ack_i) begin
                        rom_ce_reg <= 1'b0;
                        if (flush) begin
                            state_reg <= FETCH_IDLE;
                        end else begin
                            inst_buf_reg <= rom_data_i;
                            buf_pc_reg   <= rom_addr_reg;
                            state_reg    <= FETCH_HOLD;
                        end
                    end else if (tmo_hit) begin
                        rom_ce_reg    <= 1'b0;
                        fetch_err_reg <= 1'b1;
                        state_reg     <= FETCH_IDLE;
                    end else if (flush || !fetch_en) begin
                        // The memory still owes us a beat; keep the request up.
                        tmo_cnt_reg <= '0;
                        state_reg   <= FETCH_DRAIN;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                FETCH_DRAIN: begin
                    if (rom_ack_i) begin
                        rom_ce_reg <= 1'b0;
                        state_reg  <= FETCH_IDLE;
                    end else if (tmo_hit) begin
                        rom_ce_reg    <= 1'b0;
                        fetch_err_reg <= 1'b1;
                        state_reg     <= FETCH_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (flush || !fetch_en) begin
                        state_reg <= FETCH_IDLE;
                    end else if (pc_i != buf_pc_reg) begin
                        rom_addr_reg <= pc_i;
                        rom_ce_reg   <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= FETCH_WAIT;
                    end
                end
                default: begin
                    rom_ce_reg <= 1'b0;
                    state_reg  <= FETCH_IDLE;
                end
            endcase
        end
    end

    // The buffer only serves the pipeline while the PC still points at it.
    assign fetch_valid = (state_reg == FETCH_HOLD) && (pc_i == buf_pc_reg);

    assign stallreq_o  = fetch_valid ? 1'b0 : fetch_en;
    assign if_pc_o     = fetch_valid ? buf_pc_reg : ZERO_WORD;
    assign if_inst_o   = fetch_valid ? inst_buf_reg : ZERO_WORD;
    assign rom_ce_o    = rom_ce_reg;
    assign rom_addr_o  = rom_addr_reg;
    assign fetch_err_o = fetch_err_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [7:0] TMO = 8'd255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        flush = 1'b0;
    logic        rom_ack_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] rom_data_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_o;
    logic        fetch_err_o;

    always #5 clk = ~clk;

    inst_fetch #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .flush       (flush),
        .rom_ack_i   (rom_ack_i),
        .rom_data_i  (rom_data_i),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .if_pc_o     (if_pc_o),
        .if_inst_o   (if_inst_o),
        .stallreq_o  (stallreq_o),
        .fetch_err_o (fetch_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an outstanding request (possibly doomed to be
    // thrown away) and a buffered instruction that is either held or not.
    bit          m_live = 1'b0;
    bit          m_req = 1'b0;
    bit          m_doomed = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_buf_pc = '0;
    logic [31:0] m_inst = '0;
    int          m_age = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_req = 1'b0; m_doomed = 1'b0; m_hold = 1'b0;
            m_err = 1'b0; m_addr = '0; m_buf_pc = '0; m_inst = '0; m_age = 0;
        end else if (m_live) begin
            m_err = 1'b0;
            if (m_req) begin
                if (rom_ack_i) begin
                    if (!(m_doomed || flush)) begin
                        m_hold = 1'b1; m_buf_pc = m_addr; m_inst = rom_data_i;
                    end
                    m_req = 1'b0; m_doomed = 1'b0;
                end else if (m_age + 1 >= int'(TMO)) begin
                    m_req = 1'b0; m_doomed = 1'b0; m_err = 1'b1;
                end else if (!m_doomed && (flush || !ce_i)) begin
                    m_doomed = 1'b1; m_age = 0;
                end else begin
                    m_age++;
                end
            end else if (m_hold) begin
                if (flush || !ce_i) begin
                    m_hold = 1'b0;
                end else if (pc_i != m_buf_pc) begin
                    m_hold = 1'b0; m_req = 1'b1; m_addr = pc_i; m_age = 0; m_doomed = 1'b0;
                end
            end else if (ce_i && !flush) begin
                m_req = 1'b1; m_addr = pc_i; m_age = 0; m_doomed = 1'b0;
            end
        end
    end

    // Compare process: every cycle, mid-low-phase, once inputs have settled.
    always @(negedge clk) begin : compare
        logic v;
        #2;
        if (m_live) begin
            v = m_hold && (pc_i == m_buf_pc);
            chk("rom_ce",    32'(rom_ce_o),    32'(m_req));
            chk("rom_addr",  rom_addr_o,       m_addr);
            chk("fetch_err", 32'(fetch_err_o), 32'(m_err));
            chk("stallreq",  32'(stallreq_o),  v ? 32'd0 : 32'(ce_i));
            chk("if_pc",     if_pc_o,          v ? m_buf_pc : 32'd0);
            chk("if_inst",   if_inst_o,        v ? m_inst : 32'd0);
        end
    end

    task automatic drive(input logic r, input logic c, input logic f, input logic a,
                         input logic [31:0] p, input logic [31:0] d);
        @(negedge clk);
        rst = r; ce_i = c; flush = f; rom_ack_i = a; pc_i = p; rom_data_i = d;
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int stall_n;
        int ce_n;
        bit bad;
        bit err_seen;
        logic r, c, f, a;
        logic [31:0] p;

        // Reset state
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_rom_ce", 32'(rom_ce_o), 0);
        chk("rst_rom_addr", rom_addr_o, 0);
        chk("rst_fetch_err", 32'(fetch_err_o), 0);
        chk("rst_if_inst", if_inst_o, 0);

        // Single-cycle ack at pc 0
        drive(0, 1, 0, 0, 0, 0);
        chk("t1_idle_stall", 32'(stallreq_o), 1);
        drive(0, 1, 0, 1, 0, 32'h3C010001);
        chk("t1_req_ce", 32'(rom_ce_o), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("t1_if_inst", if_inst_o, 32'h3C010001);
        chk("t1_if_pc", if_pc_o, 0);
        chk("t1_stall", 32'(stallreq_o), 0);
        chk("t1_model_pin", m_inst, 32'h3C010001);
        $display("T1 pc=%08h inst=%08h", if_pc_o, if_inst_o);

        // Ack delayed to the fifth wait cycle
        stall_n = 0; bad = 1'b0;
        drive(0, 1, 0, 0, 32'h10, 0);
        stall_n += int'(stallreq_o);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 32'h10, 0);
            stall_n += int'(stallreq_o);
            if (rom_addr_o !== 32'h10 || rom_ce_o !== 1'b1) bad = 1'b1;
        end
        drive(0, 1, 0, 1, 32'h10, 32'h24020005);
        stall_n += int'(stallreq_o);
        if (rom_addr_o !== 32'h10 || rom_ce_o !== 1'b1) bad = 1'b1;
        drive(0, 1, 0, 0, 32'h10, 0);
        chk("t2_stall_cycles", 32'(stall_n), 6);
        chk("t2_addr_stable", 32'(bad), 0);
        chk("t2_if_inst", if_inst_o, 32'h24020005);
        chk("t2_if_pc", if_pc_o, 32'h10);
        $display("T2 pc=%08h inst=%08h stalls=%0d", if_pc_o, if_inst_o, stall_n);

        // Flush in the second wait cycle, ack arrives three cycles later
        drive(0, 1, 0, 0, 32'h20, 0);
        drive(0, 1, 0, 0, 32'h20, 0);
        drive(0, 1, 1, 0, 32'h20, 0);
        drive(0, 1, 0, 0, 32'h40, 0);
        chk("t3_drain_ce", 32'(rom_ce_o), 1);
        chk("t3_drain_addr", rom_addr_o, 32'h20);
        drive(0, 1, 0, 0, 32'h40, 0);
        drive(0, 1, 0, 1, 32'h40, 32'hDEADBEEF);
        drive(0, 1, 0, 0, 32'h40, 0);
        chk("t3_idle_ce", 32'(rom_ce_o), 0);
        chk("t3_discard", if_inst_o, 0);
        chk("t3_idle_stall", 32'(stallreq_o), 1);
        drive(0, 1, 0, 1, 32'h40, 32'h8C430000);
        chk("t3_new_ce", 32'(rom_ce_o), 1);
        chk("t3_new_addr", rom_addr_o, 32'h40);
        drive(0, 1, 0, 0, 32'h40, 0);
        chk("t3_if_inst", if_inst_o, 32'h8C430000);
        $display("T3 pc=%08h inst=%08h", if_pc_o, if_inst_o);

        // Flush and ack in the same cycle
        drive(0, 1, 0, 0, 32'h44, 0);
        drive(0, 1, 1, 1, 32'h44, 32'h11111111);
        drive(0, 1, 0, 0, 32'h44, 0);
        chk("t4_ce_dropped", 32'(rom_ce_o), 0);
        chk("t4_no_deliver", if_inst_o, 0);
        drive(0, 1, 0, 1, 32'h44, 32'hAC220004);
        drive(0, 1, 0, 0, 32'h44, 0);
        chk("t4_if_inst", if_inst_o, 32'hAC220004);
        $display("T4 pc=%08h inst=%08h", if_pc_o, if_inst_o);

        // Request timeout, then a late ack
        drive(0, 1, 0, 0, 32'h80, 0);
        ce_n = 0; err_seen = 1'b0;
        for (int i = 0; i < 255; i++) begin
            drive(0, 1, 0, 0, 32'h80, 0);
            ce_n += int'(rom_ce_o);
            if (fetch_err_o) err_seen = 1'b1;
        end
        chk("t5_req_cycles", 32'(ce_n), 255);
        chk("t5_no_early_err", 32'(err_seen), 0);
        drive(0, 0, 0, 1, 32'h80, 32'h00000BAD);
        chk("t5_err_pulse", 32'(fetch_err_o), 1);
        chk("t5_ce_dropped", 32'(rom_ce_o), 0);
        drive(0, 0, 0, 0, 32'h80, 0);
        chk("t5_err_one_cycle", 32'(fetch_err_o), 0);
        chk("t5_late_ack_ce", 32'(rom_ce_o), 0);
        chk("t5_late_ack_inst", if_inst_o, 0);
        chk("t5_ce_off_stall", 32'(stallreq_o), 0);
        $display("T5 timeout after %0d request cycles", ce_n);

        // Long external stall while holding
        drive(0, 1, 0, 0, 32'h100, 0);
        drive(0, 1, 0, 1, 32'h100, 32'h0000000C);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 1'($urandom_range(0, 1)), 32'h100, $urandom);
            if (rom_ce_o !== 1'b0 || if_inst_o !== 32'h0000000C || stallreq_o !== 1'b0) bad = 1'b1;
        end
        chk("t6_hold_stable", 32'(bad), 0);
        $display("T6 held inst=%08h for 10 cycles", if_inst_o);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 9) < 4);
            if (m_hold && pc_i == m_buf_pc && $urandom_range(0, 9) < 6)
                p = pc_i + 32'd4;
            else if ($urandom_range(0, 19) == 0)
                p = 32'($urandom_range(0, 255)) << 2;
            else
                p = pc_i;
            drive(r, c, f, a, p, $urandom);
        end
        drive(0, 0, 0, 0, pc_i, 0);
        $display("RANDOM 3000 cycles done");

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 8'd255: maximum cycles a ROM request may stay unacknowledged.
REQ-002 SHALL have one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high (`RstEnable).
REQ-005 pc_i  input  32  fetch address from the PC register.
REQ-006 ce_i  input  1  PC-register chip enable; fetch permitted when `ChipEnable.
REQ-007 flush  input  1  exception flush from CTRL.
REQ-008 rom_ack_i  input  1  instruction memory: data valid this cycle.
REQ-009 rom_data_i  input  32  instruction word from memory.
REQ-010 rom_ce_o  output  1  memory request, held until ack.
REQ-011 rom_addr_o  output  32  request address, stable while rom_ce_o=1.
REQ-012 if_pc_o  output  32  PC of the delivered instruction to IF/ID.
REQ-013 if_inst_o  output  32  delivered instruction to IF/ID.
REQ-014 stallreq_o  output  1  to CTRL: instruction for pc_i not yet available.
REQ-015 fetch_err_o  output  1  one-cycle pulse on request timeout.

Function
REQ-016 SHALL implement states IDLE, WAIT, HOLD, DRAIN.
REQ-017 rom_ce_o, rom_addr_o, fetch_err_o, buffer and state SHALL be registered; stallreq_o, if_pc_o and if_inst_o SHALL be combinational from state, buffer and pc_i.
REQ-018 IDLE: if ce_i=1 and flush=0, latch rom_addr_o<=pc_i, set rom_ce_o<=1, go to WAIT; otherwise stay.
REQ-019 WAIT with rom_ack_i=1 and flush=0: inst_buf<=rom_data_i, buf_pc<=rom_addr_o, rom_ce_o<=0, go to HOLD.
REQ-020 WAIT with flush=1 or ce_i=0, no ack: go to DRAIN, keeping rom_ce_o and rom_addr_o.
REQ-021 WAIT with flush=1 and rom_ack_i=1 in the same cycle: discard the data, rom_ce_o<=0, go to IDLE.
REQ-022 DRAIN: hold request until rom_ack_i, discard the data, rom_ce_o<=0, go to IDLE.
REQ-023 HOLD with flush=1 or ce_i=0: go to IDLE.
REQ-024 HOLD with pc_i!=buf_pc: issue new request for pc_i, go to WAIT.
REQ-025 HOLD with pc_i==buf_pc: stay; buffered instruction remains valid for any length of stall.
REQ-026 Valid SHALL mean state=HOLD and pc_i==buf_pc; when valid, stallreq_o=0, if_pc_o=buf_pc, if_inst_o=inst_buf.
REQ-027 When not valid, stallreq_o SHALL be 1 if ce_i=1 (0 if ce_i=0), and if_pc_o=if_inst_o=`ZeroWord (NOP).
REQ-028 Timeout counter (8 bit) SHALL clear on entering WAIT or DRAIN and increment each unacknowledged cycle there.
REQ-029 On reaching TIMEOUT_CYC: rom_ce_o<=0, fetch_err_o<=1 for one cycle, go to IDLE; an ack arriving later SHALL be ignored.
REQ-030 rom_ack_i in IDLE or HOLD SHALL be ignored.
REQ-031 Minimum sequential throughput SHALL be one instruction per 3 cycles with single-cycle ack (HOLD, HOLD-mismatch, WAIT).

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, rom_ce_o=0, rom_addr_o=0, inst_buf=0, buf_pc=0, counter=0, fetch_err_o=0, regardless of the current state.
REQ-033 Reset during WAIT SHALL abandon the transaction; a late ack after reset SHALL be ignored.

Structure
REQ-034 State encodings, `ZeroWord, `ChipEnable, `RstEnable, `InstAddrBus and `InstBus SHALL come from shared defines.v.
REQ-035 Single flat module; no sub-module is warranted.

Verification
REQ-036 Reset, ce_i=1, pc_i=0, ack 1 cycle after request, data 0x3C010001 -> if_inst_o=0x3C010001, if_pc_o=0, stallreq_o=0 in cycle 3.
REQ-037 pc_i=0x10, ack delayed 5 cycles -> stallreq_o=1 for 6 cycles, rom_addr_o=0x10 stable throughout, then data delivered.
REQ-038 Flush 2 cycles into WAIT, ack 3 cycles later with 0xDEADBEEF -> data discarded, IDLE, new request for new_pc.
REQ-039 Flush and ack in the same cycle -> no delivery, rom_ce_o=0 next cycle.
REQ-040 No ack for 255 cycles -> fetch_err_o=1 for exactly one cycle, rom_ce_o=0; a later ack has no effect.
REQ-041 HOLD with external stall for 10 cycles at constant pc_i -> no new request; if_inst_o is held.
